// File: rtl/flicker_pkg.sv
// Shared types and constants for the candle-flicker brightness generator.
// Optional gust dips are enabled by defining FLICKER_GUST_EN.
package flicker_pkg;

    typedef enum logic [1:0] {
        PICK  = 2'd0,
        RAMP  = 2'd1,
        DWELL = 2'd2
    } state_t;

    localparam int          LFSR_W      = 16;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [3:0]  GUST_NIBBLE = 4'h0;

    // Right-shifting Galois step: feedback from bit 0 into the tap mask.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; advances once per enabled clock.
// A zero seed is replaced by 1 so the register never locks up.
module lfsr16
    import flicker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (enable) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/flicker_gen.sv
// Frame-synchronous brightness ramp/dwell sequencer driven by an LFSR.
// Define FLICKER_GUST_EN to allow occasional dips below MIN_LEVEL.
module flicker_gen
    import flicker_pkg::*;
#(
    parameter int          MIN_LEVEL  = 64,
    parameter int          STEP       = 4,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          DWELL_BITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame,
    output logic [7:0] value,
    output logic [7:0] target,
    output logic       new_target
);

    localparam int         DW    = DWELL_BITS + 1;
    localparam logic [7:0] MIN_L = 8'(MIN_LEVEL);
    localparam logic [8:0] SPAN  = 9'(256 - MIN_LEVEL);
    localparam logic [8:0] STEP9 = 9'(STEP);

    state_t            state_q, state_d;
    logic [7:0]        value_d, target_d;
    logic [DW-1:0]     dwell_q, dwell_d, dwell_load;
    logic              nt_q;
    logic [LFSR_W-1:0] lfsr;
    logic [16:0]       prod;
    logic [7:0]        pick_tgt, ramp_val;
    logic [8:0]        v9, t9;
    logic              lfsr_unused;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .seed   (SEED),
        .state  (lfsr)
    );

    assign prod = {9'b0, lfsr[7:0]} * {8'b0, SPAN};

`ifdef FLICKER_GUST_EN
    assign pick_tgt = (lfsr[15:12] == GUST_NIBBLE) ? {2'b00, lfsr[7:2]}
                                                   : MIN_L + prod[15:8];
`else
    assign pick_tgt = MIN_L + prod[15:8];
`endif

    assign lfsr_unused = ^{lfsr[15:8], prod[16], prod[7:0]};
    assign dwell_load  = {1'b0, lfsr[DWELL_BITS-1:0]} + DW'(1);

    // 9-bit distances so a full step never wraps past the target.
    assign v9 = {1'b0, value};
    assign t9 = {1'b0, target};

    always_comb begin
        ramp_val = target;
        if (v9 < t9) begin
            if (t9 - v9 > STEP9) ramp_val = 8'(v9 + STEP9);
        end else if (v9 > t9) begin
            if (v9 - t9 > STEP9) ramp_val = 8'(v9 - STEP9);
        end
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value;
        target_d = target;
        dwell_d  = dwell_q;
        if (enable) begin
            unique case (state_q)
                PICK: begin
                    target_d = pick_tgt;
                    state_d  = RAMP;
                end
                RAMP: begin
                    if (frame) begin
                        value_d = ramp_val;
                        if (ramp_val == target) begin
                            dwell_d = dwell_load;
                            state_d = DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (frame) begin
                        dwell_d = dwell_q - DW'(1);
                        if (dwell_q <= DW'(1)) state_d = PICK;
                    end
                end
                default: state_d = PICK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PICK;
            value   <= MIN_L;
            target  <= MIN_L;
            dwell_q <= '0;
            nt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            value   <= value_d;
            target  <= target_d;
            dwell_q <= dwell_d;
            nt_q    <= enable && (state_q == PICK);
        end
    end

    // A stalled cycle never shows the pulse.
    assign new_target = nt_q & enable;

endmodule
